mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction RAM (512 x 16) between two requesters.
  - Port A: the CPU.
  - Port B: a debug/loader master that preloads programs and inspects results (e.g. reads mem[25] after halt).
- Sits between both masters and the RAM; drives the RAM command/address/data bus.
- Sequences each access with a req/ack handshake and round-robin arbitration.

Parameters:
- AW, 9, address width (word address, 512 words)
- DW, 16, data word width

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- a_req  input  1  port A request; held with a_we/a_addr/a_wdata stable until a_ack
- a_we  input  1  port A: 1 = write, 0 = read
- a_addr  input  AW  port A word address
- a_wdata  input  DW  port A write data
- a_rdata  output  DW  port A read data, valid while a_ack=1, held until next A read completes
- a_ack  output  1  port A one-cycle completion pulse
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack: same widths and meaning for port B
- mem_cmd  output  2  RAM command: 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE
- mem_addr  output  AW  RAM address
- mem_wdata  output  DW  RAM write data
- mem_rdata  input  DW  RAM read data; registered RAM, valid the cycle after MREAD
- owner  output  2  2'b00 none, 2'b01 A, 2'b10 B; current transaction owner

Behaviour:
- Reset values (all registered): state IDLE, mem_cmd MNONE, mem_addr 0, mem_wdata 0, a_ack/b_ack 0, a_rdata/b_rdata 0, owner 0, last_grant = B (so A wins the first tie).
- Reset mid-transaction aborts immediately to IDLE. No ack is issued. Any partially issued read is discarded.
- States and transitions:
  - IDLE: sample a_req/b_req.
    - Neither set: stay.
    - One set: grant it.
    - Both set: grant the port not equal to last_grant.
    - On grant: latch we/addr/wdata of the winner, set owner and last_grant, go to WR if we=1, else RD.
  - WR: mem_cmd=MWRITE, mem_addr/mem_wdata = latched values. Next state DONE.
  - RD: mem_cmd=MREAD, mem_addr = latched addr. Next state RWAIT.
  - RWAIT: mem_cmd=MNONE; capture mem_rdata into the owner's rdata register at the end of the cycle. Next state DONE.
  - DONE: owner's ack=1 for exactly this cycle; mem_cmd=MNONE; requests ignored. Next state IDLE; owner returns to 0.
- mem_cmd is MNONE in every state except WR/RD. It is never driven for both ports at once.
- Latency from a req sampled high in IDLE at cycle N:
  - write: MWRITE in N+1, ack in N+2.
  - read: MREAD in N+1, ack + rdata valid in N+3.
- Handshake:
  - The requester must keep req and its fields stable until ack.
  - It may hold req high after ack to issue a back-to-back access; a new transaction is then sampled in the IDLE cycle after DONE.
  - Minimum period per access: 3 cycles (write), 4 cycles (read).
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B. Neither port waits more than one foreign transaction.
- The non-owner's rdata is unchanged by the other port's reads.
- req dropped before ack is a protocol violation; the arbiter completes the latched transaction anyway.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
  - Defined: on a simultaneous A/B request in IDLE, A always wins; last_grant is still updated but ignored for arbitration. B can starve while A requests continuously.
  - Undefined: round-robin as above.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> mem_cmd=00, acks 0, owner 0, rdata 0 for 5 idle cycles.
- A write then read: A writes 16'hFFE9 (-23) to addr 25 -> MWRITE in N+1, a_ack at N+2. A then reads addr 25 -> a_rdata=16'hFFE9 with a_ack exactly 3 cycles after MREAD issue cycle-1. b_rdata stays 0.
- Simultaneous requests: A and B both request reads in the same cycle after reset -> A served first, B's MREAD follows A's DONE+IDLE. With both held high for 4 accesses, owner sequence is A, B, A, B.
- Fixed-priority build: same stimulus with ARB_FIXED_PRIORITY_EN -> all 4 grants go to A while a_req stays high; B is served only after A drops req.
- Reset mid-read: assert reset during RWAIT of a B read of addr 7 -> next cycle mem_cmd=00, b_ack never pulses, b_rdata=0, state IDLE.
- Back-to-back B writes: addrs 0..3, data 16'h0001..16'h0004, req held high -> one MWRITE every 3 cycles. A subsequent B read of addr 2 returns 16'h0003.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two RAM masters, the shared single-port RAM and mem_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and RAM.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic [DW-1:0] a_rdata;
  logic          a_ack;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [DW-1:0] b_rdata;
  logic          b_ack;

  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_rdata, a_ack, b_rdata, b_ack,
    output mem_cmd, mem_addr, mem_wdata, owner
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_rdata, a_ack, b_rdata, b_ack,
    input  mem_cmd, mem_addr, mem_wdata, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master req/ack arbiter in front of a registered single-port RAM. The default build uses round-robin.
// Defining ARB_FIXED_PRIORITY_EN makes port A always win a simultaneous request.
module mem_port_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, DONE} state_t;

  localparam logic [1:0] MNONE    = 2'b00;
  localparam logic [1:0] MREAD    = 2'b01;
  localparam logic [1:0] MWRITE   = 2'b10;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_A    = 2'b01;
  localparam logic [1:0] OWN_B    = 2'b10;

  state_t        r_state;
  state_t        w_nextState;
  logic [1:0]    r_owner;
  logic [1:0]    r_lastGrant;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_aRdata;
  logic [DW-1:0] r_bRdata;
  logic          w_grantA;
  logic          w_grantB;
  logic [1:0]    w_memCmd;
  logic          w_aAck;
  logic          w_bAck;

  // Grant decision is only acted on in IDLE; last_grant still tracks winners in the fixed-priority build.
  always_comb begin
    w_grantA = 1'b0;
    w_grantB = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
    w_grantA = bus.a_req;
`else
    w_grantA = bus.a_req && (!bus.b_req || (r_lastGrant == OWN_B));
`endif
    w_grantB = bus.b_req && !w_grantA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantA) begin
          w_nextState = bus.a_we ? WR : RD;
        end else if (w_grantB) begin
          w_nextState = bus.b_we ? WR : RD;
        end
      end
      WR:      w_nextState = DONE;
      RD:      w_nextState = RWAIT;
      RWAIT:   w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A synchronous reset in RWAIT wins over the capture, so a half-finished read leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_lastGrant <= OWN_B;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_aRdata    <= '0;
      r_bRdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantA) begin
            r_owner     <= OWN_A;
            r_lastGrant <= OWN_A;
            r_addr      <= bus.a_addr;
            r_wdata     <= bus.a_wdata;
          end else if (w_grantB) begin
            r_owner     <= OWN_B;
            r_lastGrant <= OWN_B;
            r_addr      <= bus.b_addr;
            r_wdata     <= bus.b_wdata;
          end
        end
        RWAIT: begin
          if (r_owner == OWN_A) begin
            r_aRdata <= bus.mem_rdata;
          end else if (r_owner == OWN_B) begin
            r_bRdata <= bus.mem_rdata;
          end
        end
        DONE: begin
          r_owner <= OWN_NONE;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_memCmd = MNONE;
    w_aAck   = 1'b0;
    w_bAck   = 1'b0;
    case (r_state)
      WR:   w_memCmd = MWRITE;
      RD:   w_memCmd = MREAD;
      DONE: begin
        w_aAck = (r_owner == OWN_A);
        w_bAck = (r_owner == OWN_B);
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_cmd   = w_memCmd;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.owner     = r_owner;
  assign bus.a_ack     = w_aAck;
  assign bus.b_ack     = w_bAck;
  assign bus.a_rdata   = r_aRdata;
  assign bus.b_rdata   = r_bRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural RAM and a transaction-timeline reference model.
// Build with ARB_FIXED_PRIORITY_EN defined to check the fixed-priority variant.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Registered single-port RAM; contents reload to a known pattern whenever reset is high.
  logic [DW-1:0] ram [512];

  function automatic logic [DW-1:0] initPattern(input int i);
    return DW'(i * 37 + 5);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) ram[i] <= initPattern(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_cmd == 2'b10) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_cmd == 2'b01) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Reference model: pending transactions per port, expected memory, and the current grant timeline.
  txn_t          qA[$];
  txn_t          qB[$];
  logic [DW-1:0] expMem [512];
  logic [DW-1:0] expRd [2];
  bit            active [2];
  bit            busy;
  int            curPort;
  txn_t          cur;
  int            startCyc;
  int            lastWinner;
  int            cyc;
  int            grantLog[$];
  int            checks;
  int            failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    qA.delete();
    qB.delete();
    active[0] = 1'b0;
    active[1] = 1'b0;
    busy = 1'b0;
    lastWinner = 1;
    expRd[0] = '0;
    expRd[1] = '0;
    for (int i = 0; i < 512; i++) expMem[i] = initPattern(i);
  endtask

  task automatic applyStimulus();
    bus.a_req = active[0];
    bus.b_req = active[1];
    if (active[0]) begin
      bus.a_we    = qA[0].we;
      bus.a_addr  = qA[0].addr;
      bus.a_wdata = qA[0].data;
    end
    if (active[1]) begin
      bus.b_we    = qB[0].we;
      bus.b_addr  = qB[0].addr;
      bus.b_wdata = qB[0].data;
    end
  endtask

  // One clock of the model: check this cycle's outputs, advance the timeline, drive the next inputs.
  task automatic checkOutput(input bit gaps);
    int         d;
    int         ackOff;
    logic [1:0] expCmd;
    logic [1:0] expOwner;
    logic       expAck [2];
    bit         wasBusy;
    bit         finishing;
    expCmd    = 2'b00;
    expOwner  = 2'b00;
    expAck[0] = 1'b0;
    expAck[1] = 1'b0;
    wasBusy   = busy;
    finishing = 1'b0;
    d         = 0;
    ackOff    = 0;
    if (busy) begin
      d        = cyc - startCyc;
      ackOff   = cur.we ? 2 : 3;
      expOwner = 2'(curPort + 1);
      if (d == 1) begin
        expCmd = cur.we ? 2'b10 : 2'b01;
        chk("mem_addr", 32'(bus.mem_addr), 32'(cur.addr));
        if (cur.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cur.data));
        grantLog.push_back(int'(bus.owner));
      end
      if (d == ackOff) begin
        expAck[curPort] = 1'b1;
        finishing = 1'b1;
        if (cur.we) expMem[cur.addr] = cur.data;
        else        expRd[curPort]   = expMem[cur.addr];
      end
    end
    chk("mem_cmd", 32'(bus.mem_cmd), 32'(expCmd));
    chk("owner",   32'(bus.owner),   32'(expOwner));
    chk("a_ack",   32'(bus.a_ack),   32'(expAck[0]));
    chk("b_ack",   32'(bus.b_ack),   32'(expAck[1]));
    chk("a_rdata", 32'(bus.a_rdata), 32'(expRd[0]));
    chk("b_rdata", 32'(bus.b_rdata), 32'(expRd[1]));
    if (finishing) begin
      if (curPort == 0) qA.delete(0);
      else              qB.delete(0);
      active[curPort] = 1'b0;
      busy = 1'b0;
    end
    if (!active[0] && qA.size() > 0 && (!gaps || $urandom_range(1, 0) == 1)) active[0] = 1'b1;
    if (!active[1] && qB.size() > 0 && (!gaps || $urandom_range(1, 0) == 1)) active[1] = 1'b1;
    if (!wasBusy && (active[0] || active[1])) begin
      if (active[0] && active[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
        curPort = 0;
`else
        curPort = (lastWinner == 1) ? 0 : 1;
`endif
      end else begin
        curPort = active[0] ? 0 : 1;
      end
      cur        = (curPort == 0) ? qA[0] : qB[0];
      lastWinner = curPort;
      startCyc   = cyc;
      busy       = 1'b1;
    end
    applyStimulus();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_cmd",   32'(bus.mem_cmd),   32'd0);
    chk("rst_owner",     32'(bus.owner),     32'd0);
    chk("rst_acks",      32'({bus.a_ack, bus.b_ack}), 32'd0);
    chk("rst_a_rdata",   32'(bus.a_rdata),   32'd0);
    chk("rst_b_rdata",   32'(bus.b_rdata),   32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic runUntilDone(input int maxCyc, input bit gaps);
    int n;
    n = 0;
    while ((qA.size() > 0 || qB.size() > 0 || busy) && n < maxCyc) begin
      checkOutput(gaps);
      n++;
    end
    chk("drain_timeout", 32'(qA.size() + qB.size() + int'(busy)), 32'd0);
  endtask

  function automatic txn_t mk(input logic we, input int addr, input logic [DW-1:0] data);
    txn_t t;
    t.we   = we;
    t.addr = AW'(addr);
    t.data = data;
    return t;
  endfunction

  initial begin
    int n;
    int expOwn;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset    = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    modelReset();

    $display("[TB] reset then idle");
    doReset();
    repeat (5) checkOutput(1'b0);

    $display("[TB] port A write -23 to addr 25, then read back");
    qA.push_back(mk(1'b1, 25, 16'hFFE9));
    runUntilDone(20, 1'b0);
    qA.push_back(mk(1'b0, 25, 16'h0000));
    runUntilDone(20, 1'b0);
    chk("a_rdata_addr25", 32'(bus.a_rdata), 32'h0000FFE9);
    chk("b_rdata_untouched", 32'(bus.b_rdata), 32'd0);

    $display("[TB] simultaneous requests, both held for 4 accesses");
    doReset();
    grantLog.delete();
    for (int i = 0; i < 4; i++) begin
      qA.push_back(mk(1'b0, 10 + i, 16'h0000));
      qB.push_back(mk(1'b0, 20 + i, 16'h0000));
    end
    runUntilDone(100, 1'b0);
    chk("grant_count", 32'(grantLog.size()), 32'd8);
    for (int i = 0; i < 8 && i < grantLog.size(); i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      expOwn = (i < 4) ? 1 : 2;
`else
      expOwn = (i % 2 == 0) ? 1 : 2;
`endif
      chk($sformatf("grant_order_%0d", i), 32'(grantLog[i]), 32'(expOwn));
    end

    $display("[TB] back-to-back port B writes, then read addr 2");
    for (int i = 0; i < 4; i++) qB.push_back(mk(1'b1, i, 16'(i + 1)));
    runUntilDone(40, 1'b0);
    qB.push_back(mk(1'b0, 2, 16'h0000));
    runUntilDone(20, 1'b0);
    chk("b_rdata_addr2", 32'(bus.b_rdata), 32'h00000003);

    $display("[TB] randomized mixed traffic on both ports");
    for (int i = 0; i < 20; i++) begin
      qA.push_back(mk(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), 16'($urandom)));
      qB.push_back(mk(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), 16'($urandom)));
    end
    runUntilDone(2000, 1'b1);

    $display("[TB] reset during RWAIT of a port B read of addr 7");
    qB.push_back(mk(1'b0, 7, 16'h0000));
    runUntilDone(20, 1'b0);
    qB.push_back(mk(1'b0, 7, 16'h0000));
    n = 0;
    while (!(busy && curPort == 1 && (cyc - startCyc) == 2) && n < 50) begin
      checkOutput(1'b0);
      n++;
    end
    chk("rwait_reached", 32'(n < 50), 32'd1);
    reset = 1'b1;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("midrst_mem_cmd", 32'(bus.mem_cmd), 32'd0);
    chk("midrst_b_ack",   32'(bus.b_ack),   32'd0);
    chk("midrst_b_rdata", 32'(bus.b_rdata), 32'd0);
    chk("midrst_owner",   32'(bus.owner),   32'd0);
    reset = 1'b0;
    modelReset();
    repeat (4) checkOutput(1'b0);

    $display("[TB] port A read after reset");
    qA.push_back(mk(1'b0, 7, 16'h0000));
    runUntilDone(20, 1'b0);
    chk("a_rdata_addr7", 32'(bus.a_rdata), 32'(initPattern(7)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
